bp_be_mem_exc_pipe: RTL and testbench

BP_BE_MEM_EXC_PIPE -- requirements
Module: bp_be_mem_exc_pipe

---
 rtl/bp_be_mem_exc_pipe.sv | 181 ++++++++++++++++++
 tb/tb_bp_be_mem_exc_pipe.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/bp_be_mem_exc_pipe.sv
// Memory-pipe exception/miss tracker: follows memory ops through mem0..mem2,
// raises exceptions or commits at mem2+1, and stalls issue on TLB/D$ misses
// until the fill completes, then requests a replay of the missing PC.
module bp_be_mem_exc_pipe #(
    parameter int unsigned vaddr_width_p = 39,
    parameter int unsigned eaddr_width_p = 64
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     flush_i,
    input  logic                     issue_v_i,
    input  logic [vaddr_width_p-1:0] issue_pc_i,
    input  logic [eaddr_width_p-1:0] issue_eaddr_i,
    input  logic                     tlb_miss_v_i,
    input  logic                     cache_miss_v_i,
    input  logic                     fencei_v_i,
    input  logic                     load_misaligned_v_i,
    input  logic                     load_page_fault_v_i,
    input  logic                     load_access_fault_v_i,
    input  logic                     store_misaligned_v_i,
    input  logic                     store_page_fault_v_i,
    input  logic                     store_access_fault_v_i,
    input  logic                     ptw_fill_v_i,
    input  logic                     cache_req_complete_i,
    output logic                     busy_o,
    output logic                     commit_v_o,
    output logic                     exc_v_o,
    output logic [3:0]               exc_cause_o,
    output logic [vaddr_width_p-1:0] exc_pc_o,
    output logic [eaddr_width_p-1:0] exc_tval_o,
    output logic                     replay_v_o,
    output logic [vaddr_width_p-1:0] replay_pc_o
);

    typedef enum logic [1:0] {
        e_ready      = 2'd0,
        e_wait_tlb   = 2'd1,
        e_wait_cache = 2'd2
    } state_e;

    state_e                     r_state;
    logic                       r_busy;
    logic                       r_commit_v;
    logic                       r_exc_v;
    logic [3:0]                 r_exc_cause;
    logic [vaddr_width_p-1:0]   r_exc_pc;
    logic [eaddr_width_p-1:0]   r_exc_tval;
    logic                       r_replay_v;
    logic [vaddr_width_p-1:0]   r_replay_pc;

    logic                       r_mem1_v;
    logic [vaddr_width_p-1:0]   r_mem1_pc;
    logic [eaddr_width_p-1:0]   r_mem1_eaddr;
    logic                       r_mem2_v;
    logic [vaddr_width_p-1:0]   r_mem2_pc;
    logic [eaddr_width_p-1:0]   r_mem2_eaddr;

    logic                       w_issue_v;
    logic                       w_exc_v;
    logic [3:0]                 w_exc_cause;
    logic                       w_tlb_miss;
    logic                       w_cache_miss;
    logic                       w_squash;
    logic                       w_clean;
    logic                       w_commit;

    // mem2 status decode: faults win over misses, TLB miss wins over cache miss
    always_comb begin
        w_issue_v    = issue_v_i & ~r_busy & ~flush_i;
        w_exc_v      = r_mem2_v & (load_misaligned_v_i | store_misaligned_v_i
                                 | load_page_fault_v_i | store_page_fault_v_i
                                 | load_access_fault_v_i | store_access_fault_v_i);
        w_exc_cause  = 4'(0);
        if (load_misaligned_v_i)         w_exc_cause = 4'(4);
        else if (store_misaligned_v_i)   w_exc_cause = 4'(6);
        else if (load_page_fault_v_i)    w_exc_cause = 4'(13);
        else if (store_page_fault_v_i)   w_exc_cause = 4'(15);
        else if (load_access_fault_v_i)  w_exc_cause = 4'(5);
        else if (store_access_fault_v_i) w_exc_cause = 4'(7);
        w_tlb_miss   = r_mem2_v & ~w_exc_v & tlb_miss_v_i;
        w_cache_miss = r_mem2_v & ~w_exc_v & ~tlb_miss_v_i & cache_miss_v_i;
        w_squash     = w_exc_v | w_tlb_miss | w_cache_miss;
        w_clean      = r_mem2_v & ~w_squash;
        // fence.i retires through the same clean-commit path as loads/stores
        w_commit     = (w_clean & fencei_v_i) | (w_clean & ~fencei_v_i);
    end

    // Stage valids/payloads; a mem2 event squashes everything younger
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_mem1_v     <= 1'b0;
            r_mem1_pc    <= '0;
            r_mem1_eaddr <= '0;
            r_mem2_v     <= 1'b0;
            r_mem2_pc    <= '0;
            r_mem2_eaddr <= '0;
        end else if (flush_i) begin
            r_mem1_v <= 1'b0;
            r_mem2_v <= 1'b0;
        end else begin
            r_mem1_v     <= w_issue_v & ~w_squash;
            r_mem2_v     <= r_mem1_v & ~w_squash;
            r_mem1_pc    <= issue_pc_i;
            r_mem1_eaddr <= issue_eaddr_i;
            r_mem2_pc    <= r_mem1_pc;
            r_mem2_eaddr <= r_mem1_eaddr;
        end
    end

    // Miss-wait FSM with registered result pulses
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state     <= e_ready;
            r_busy      <= 1'b0;
            r_commit_v  <= 1'b0;
            r_exc_v     <= 1'b0;
            r_exc_cause <= '0;
            r_exc_pc    <= '0;
            r_exc_tval  <= '0;
            r_replay_v  <= 1'b0;
            r_replay_pc <= '0;
        end else begin
            r_commit_v <= 1'b0;
            r_exc_v    <= 1'b0;
            r_replay_v <= 1'b0;
            if (flush_i) begin
                r_state <= e_ready;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    e_ready: begin
                        if (w_exc_v) begin
                            r_exc_v     <= 1'b1;
                            r_exc_cause <= w_exc_cause;
                            r_exc_pc    <= r_mem2_pc;
                            r_exc_tval  <= r_mem2_eaddr;
                        end else if (w_tlb_miss) begin
                            r_state     <= e_wait_tlb;
                            r_busy      <= 1'b1;
                            r_replay_pc <= r_mem2_pc;
                        end else if (w_cache_miss) begin
                            r_state     <= e_wait_cache;
                            r_busy      <= 1'b1;
                            r_replay_pc <= r_mem2_pc;
                        end else if (w_commit) begin
                            r_commit_v  <= 1'b1;
                        end
                    end
                    e_wait_tlb: begin
                        if (ptw_fill_v_i) begin
                            r_state    <= e_ready;
                            r_busy     <= 1'b0;
                            r_replay_v <= 1'b1;
                        end
                    end
                    e_wait_cache: begin
                        if (cache_req_complete_i) begin
                            r_state    <= e_ready;
                            r_busy     <= 1'b0;
                            r_replay_v <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= e_ready;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign busy_o      = r_busy;
    assign commit_v_o  = r_commit_v;
    assign exc_v_o     = r_exc_v;
    assign exc_cause_o = r_exc_cause;
    assign exc_pc_o    = r_exc_pc;
    assign exc_tval_o  = r_exc_tval;
    assign replay_v_o  = r_replay_v;
    assign replay_pc_o = r_replay_pc;

endmodule

// File: tb/tb_bp_be_mem_exc_pipe.sv
// Bench for bp_be_mem_exc_pipe: directed scenarios plus random traffic, all
// checked against an in-flight-queue reference model.
module tb_bp_be_mem_exc_pipe;

    localparam int unsigned VW = 39;
    localparam int unsigned EW = 64;

    logic          clk = 1'b0;
    logic          reset_i;
    logic          flush_i, issue_v_i;
    logic [VW-1:0] issue_pc_i;
    logic [EW-1:0] issue_eaddr_i;
    logic          tlb_miss_v_i, cache_miss_v_i, fencei_v_i;
    logic          load_misaligned_v_i, load_page_fault_v_i, load_access_fault_v_i;
    logic          store_misaligned_v_i, store_page_fault_v_i, store_access_fault_v_i;
    logic          ptw_fill_v_i, cache_req_complete_i;
    logic          busy_o, commit_v_o, exc_v_o, replay_v_o;
    logic [3:0]    exc_cause_o;
    logic [VW-1:0] exc_pc_o, replay_pc_o;
    logic [EW-1:0] exc_tval_o;

    int n_checks = 0;
    int n_fail   = 0;

    bp_be_mem_exc_pipe #(.vaddr_width_p(VW), .eaddr_width_p(EW)) dut (
        .clk_i(clk), .reset_i(reset_i), .flush_i(flush_i),
        .issue_v_i(issue_v_i), .issue_pc_i(issue_pc_i), .issue_eaddr_i(issue_eaddr_i),
        .tlb_miss_v_i(tlb_miss_v_i), .cache_miss_v_i(cache_miss_v_i), .fencei_v_i(fencei_v_i),
        .load_misaligned_v_i(load_misaligned_v_i), .load_page_fault_v_i(load_page_fault_v_i),
        .load_access_fault_v_i(load_access_fault_v_i),
        .store_misaligned_v_i(store_misaligned_v_i), .store_page_fault_v_i(store_page_fault_v_i),
        .store_access_fault_v_i(store_access_fault_v_i),
        .ptw_fill_v_i(ptw_fill_v_i), .cache_req_complete_i(cache_req_complete_i),
        .busy_o(busy_o), .commit_v_o(commit_v_o), .exc_v_o(exc_v_o), .exc_cause_o(exc_cause_o),
        .exc_pc_o(exc_pc_o), .exc_tval_o(exc_tval_o),
        .replay_v_o(replay_v_o), .replay_pc_o(replay_pc_o)
    );

    always #5 clk = ~clk;

    // Reference model: list of in-flight ops tagged with their pipeline age
    typedef struct {
        logic [63:0] pc;
        logic [63:0] ea;
        int          age;
    } ent_t;

    ent_t        m_q[$];
    bit          m_busy, m_wait_tlb;
    bit          e_commit, e_exc, e_replay;
    logic [63:0] m_cause, m_epc, m_tval, m_rpc;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_busy = 0; m_wait_tlb = 0;
        e_commit = 0; e_exc = 0; e_replay = 0;
        m_cause = 0; m_epc = 0; m_tval = 0; m_rpc = 0;
    endtask

    task automatic clear_inputs();
        flush_i = 0; issue_v_i = 0; issue_pc_i = '0; issue_eaddr_i = '0;
        tlb_miss_v_i = 0; cache_miss_v_i = 0; fencei_v_i = 0;
        load_misaligned_v_i = 0; load_page_fault_v_i = 0; load_access_fault_v_i = 0;
        store_misaligned_v_i = 0; store_page_fault_v_i = 0; store_access_fault_v_i = 0;
        ptw_fill_v_i = 0; cache_req_complete_i = 0;
    endtask

    // Predict the outputs visible after the coming clock edge
    task automatic model_step();
        bit   accept, squash, fault;
        int   idx;
        int   cause;
        bit   flags[6];
        int   codes[6];
        codes = '{4, 6, 13, 15, 5, 7};
        flags = '{load_misaligned_v_i, store_misaligned_v_i, load_page_fault_v_i,
                  store_page_fault_v_i, load_access_fault_v_i, store_access_fault_v_i};
        accept = issue_v_i && !m_busy && !flush_i;
        e_commit = 0; e_exc = 0; e_replay = 0;
        if (flush_i) begin
            m_q.delete();
            m_busy = 0;
        end else if (m_busy) begin
            if ((m_wait_tlb && ptw_fill_v_i) || (!m_wait_tlb && cache_req_complete_i)) begin
                m_busy = 0;
                e_replay = 1;
            end
        end else begin
            squash = 0;
            idx = -1;
            for (int i = 0; i < m_q.size(); i++) if (m_q[i].age == 2) idx = i;
            if (idx >= 0) begin
                fault = 0; cause = 0;
                for (int k = 0; k < 6; k++) if (flags[k] && !fault) begin fault = 1; cause = codes[k]; end
                if (fault) begin
                    e_exc = 1; m_cause = 64'(cause); m_epc = m_q[idx].pc; m_tval = m_q[idx].ea;
                    squash = 1;
                end else if (tlb_miss_v_i || cache_miss_v_i) begin
                    m_busy = 1; m_wait_tlb = tlb_miss_v_i; m_rpc = m_q[idx].pc;
                    squash = 1;
                end else begin
                    e_commit = 1;
                end
                m_q.delete(idx);
            end
            if (squash) m_q.delete();
            else begin
                for (int i = 0; i < m_q.size(); i++) m_q[i].age++;
                if (accept) m_q.push_back('{64'(issue_pc_i), 64'(issue_eaddr_i), 1});
            end
        end
    endtask

    task automatic compare(input string pfx);
        check({pfx, "_busy"},   64'(busy_o),      64'(m_busy));
        check({pfx, "_commit"}, 64'(commit_v_o),  64'(e_commit));
        check({pfx, "_exc"},    64'(exc_v_o),     64'(e_exc));
        check({pfx, "_replay"}, 64'(replay_v_o),  64'(e_replay));
        check({pfx, "_cause"},  64'(exc_cause_o), m_cause);
        check({pfx, "_epc"},    64'(exc_pc_o),    m_epc);
        check({pfx, "_tval"},   exc_tval_o,       m_tval);
        check({pfx, "_rpc"},    64'(replay_pc_o), m_rpc);
    endtask

    // One cycle: inputs already set at negedge; predict, clock, compare, clear
    task automatic step(input string pfx);
        model_step();
        @(posedge clk);
        #1;
        compare(pfx);
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic issue(input logic [VW-1:0] pc, input logic [EW-1:0] ea);
        issue_v_i = 1; issue_pc_i = pc; issue_eaddr_i = ea;
    endtask

    initial begin
        clear_inputs();
        model_reset();
        reset_i = 1;
        @(negedge clk); @(negedge clk);
        compare("reset");
        reset_i = 0;

        // Clean load commits exactly at N+3
        issue(39'h1000, 64'h2000); step("c0");
        step("c1");
        step("c2");
        check("clean_commit", 64'(commit_v_o), 64'd1);

        // Store misaligned beats store page fault
        issue(39'h1004, 64'h3003); step("s0");
        step("s1");
        store_misaligned_v_i = 1; store_page_fault_v_i = 1; step("s2");
        check("st_mis_cause", 64'(exc_cause_o), 64'd6);
        check("st_mis_tval",  exc_tval_o, 64'h3003);

        // TLB miss, fill five cycles later, replay
        issue(39'h1008, 64'h4000); step("t0");
        step("t1");
        tlb_miss_v_i = 1; step("t2");
        check("tlb_busy", 64'(busy_o), 64'd1);
        for (int i = 0; i < 4; i++) step("tw");
        ptw_fill_v_i = 1; step("tf");
        check("tlb_replay_pc", 64'(replay_pc_o), 64'h1008);

        // Back-to-back with cache miss on the older op
        issue(39'h100, 64'h10); step("b0");
        issue(39'h104, 64'h14); step("b1");
        cache_miss_v_i = 1; step("b2");
        for (int i = 0; i < 3; i++) step("bw");
        cache_req_complete_i = 1; step("bf");
        check("cm_replay_pc", 64'(replay_pc_o), 64'h100);
        for (int i = 0; i < 3; i++) step("bi");

        // Flush wins over a simultaneous cache completion
        issue(39'h200, 64'h20); step("f0");
        step("f1");
        cache_miss_v_i = 1; step("f2");
        step("fw");
        flush_i = 1; cache_req_complete_i = 1; step("ff");
        step("fi");

        // Async reset while waiting on a TLB fill
        issue(39'h300, 64'h30); step("r0");
        step("r1");
        tlb_miss_v_i = 1; step("r2");
        #2 reset_i = 1;
        #1 check("async_rst_busy", 64'(busy_o), 64'd0);
        model_reset();
        @(negedge clk);
        reset_i = 0;
        for (int i = 0; i < 3; i++) begin ptw_fill_v_i = 1; cache_req_complete_i = 1; step("ra"); end

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            issue_v_i              = ($urandom_range(0, 9) < 6);
            issue_pc_i             = VW'({$urandom, $urandom});
            issue_eaddr_i          = {$urandom, $urandom};
            flush_i                = ($urandom_range(0, 39) == 0);
            tlb_miss_v_i           = ($urandom_range(0, 11) == 0);
            cache_miss_v_i         = ($urandom_range(0, 7) == 0);
            fencei_v_i             = ($urandom_range(0, 7) == 0);
            load_misaligned_v_i    = ($urandom_range(0, 19) == 0);
            load_page_fault_v_i    = ($urandom_range(0, 19) == 0);
            load_access_fault_v_i  = ($urandom_range(0, 19) == 0);
            store_misaligned_v_i   = ($urandom_range(0, 19) == 0);
            store_page_fault_v_i   = ($urandom_range(0, 19) == 0);
            store_access_fault_v_i = ($urandom_range(0, 19) == 0);
            ptw_fill_v_i           = ($urandom_range(0, 3) == 0);
            cache_req_complete_i   = ($urandom_range(0, 3) == 0);
            step("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
